// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants shared by the VGA timing generator and its users.
package vga_pkg;
   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int CW       = 10;
   localparam int DIV_W    = 4;
   localparam logic SYNC_ACTIVE = 1'b0;
   typedef logic [CW-1:0] coord_t;
endpackage

// File: rtl/pix_clk_en.sv
// pix_clk_en: one-clk pixel enable pulse every CLK_DIV system clocks.
module pix_clk_en import vga_pkg::*; #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   output logic pix_en_o
);
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             en_q, en_d;
   always_comb begin
      en_d  = cnt_q == DIV_W'(CLK_DIV - 1);
      cnt_d = en_d ? '0 : cnt_q + DIV_W'(1);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         en_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         en_q  <= en_d;
      end
   end
   assign pix_en_o = en_q;
   if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
      $error("pix_clk_en: CLK_DIV must be 1..16");
   end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters plus sync/video_on decodes delayed to line up
// with pixel data fetched from video memory.
module vga_timing_gen #(
   parameter int   H_ACTIVE    = vga_pkg::H_ACTIVE,
   parameter int   H_FP        = vga_pkg::H_FP,
   parameter int   H_SYNC      = vga_pkg::H_SYNC,
   parameter int   H_BP        = vga_pkg::H_BP,
   parameter int   V_ACTIVE    = vga_pkg::V_ACTIVE,
   parameter int   V_FP        = vga_pkg::V_FP,
   parameter int   V_SYNC      = vga_pkg::V_SYNC,
   parameter int   V_BP        = vga_pkg::V_BP,
   parameter int   CLK_DIV     = 4,
   parameter int   PIPE_DLY    = 2,
   parameter logic SYNC_ACTIVE = vga_pkg::SYNC_ACTIVE
) (
   input  logic       clk,
   input  logic       reset,
   output logic       pix_en,
   output logic [9:0] pixel_column,
   output logic [9:0] pixel_row,
   output logic       video_on,
   output logic       horiz_sync,
   output logic       vert_sync,
   output logic       frame_start
);
   localparam int CW      = vga_pkg::CW;
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int NS      = (PIPE_DLY == 0) ? 1 : PIPE_DLY;
   // Inactive pipeline word {video_on, horiz_sync, vert_sync}, syncs already at output polarity.
   localparam logic [2:0] IDLE = {1'b0, ~SYNC_ACTIVE, ~SYNC_ACTIVE};

   logic [CW-1:0] col_q, col_d, row_q, row_d;
   logic          fs_q, fs_d, h_end, v_end;
   logic [2:0]    dec;
   logic [2:0]    pipe_q [NS];

   pix_clk_en #(.CLK_DIV(CLK_DIV)) u_div (
      .clk      (clk),
      .reset    (reset),
      .pix_en_o (pix_en)
   );

   always_comb begin
      h_end = col_q == CW'(H_TOTAL - 1);
      v_end = row_q == CW'(V_TOTAL - 1);
      col_d = pix_en ? (h_end ? '0 : col_q + CW'(1)) : col_q;
      row_d = (pix_en && h_end) ? (v_end ? '0 : row_q + CW'(1)) : row_q;
      fs_d  = pix_en && h_end && v_end;
      dec   = {col_q < CW'(H_ACTIVE) && row_q < CW'(V_ACTIVE),
               (col_q >= CW'(H_ACTIVE + H_FP) && col_q < CW'(H_ACTIVE + H_FP + H_SYNC)) ? SYNC_ACTIVE : ~SYNC_ACTIVE,
               (row_q >= CW'(V_ACTIVE + V_FP) && row_q < CW'(V_ACTIVE + V_FP + V_SYNC)) ? SYNC_ACTIVE : ~SYNC_ACTIVE};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col_q <= '0;
         row_q <= '0;
         fs_q  <= 1'b0;
         for (int i = 0; i < NS; i++) pipe_q[i] <= IDLE;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
         fs_q  <= fs_d;
         if (pix_en) begin
            pipe_q[0] <= dec;
            for (int i = 1; i < NS; i++) pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign pixel_column = col_q;
   assign pixel_row    = row_q;
   assign frame_start  = fs_q;
   assign {video_on, horiz_sync, vert_sync} = pipe_q[NS-1];

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must fit 10-bit counters");
   end
   if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_bad_dly
      $error("vga_timing_gen: PIPE_DLY must be 0..4");
   end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- VGA display timing generator for 640x480 at 60 Hz, running on the 100 MHz system clock with a pixel clock enable.
- Feeds pixel_row/pixel_column to the RojoBot video interface (vid_row/vid_col, scaled externally) and to the downstream colorizer.
- Produces horiz_sync, vert_sync and video_on, delayed by PIPE_DLY pixel ticks so they line up with pixel data returned from the bot's video memory.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 4, system clocks per pixel; legal range 1..16
- PIPE_DLY, 2, pixel-tick delay applied to sync/video_on; legal range 0..4
- SYNC_ACTIVE, 0, asserted level of both syncs

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high reset
- pix_en  out  1  one-clk pulse, once every CLK_DIV clocks
- pixel_column  out  10  horizontal counter, 0..H_TOTAL-1 (H_TOTAL=800)
- pixel_row  out  10  vertical counter, 0..V_TOTAL-1 (V_TOTAL=525)
- video_on  out  1  active-region flag, delayed PIPE_DLY ticks
- horiz_sync  out  1  delayed PIPE_DLY ticks
- vert_sync  out  1  delayed PIPE_DLY ticks
- frame_start  out  1  one-clk pulse at the start of a frame

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values (all registered):
  - divider count 0; pix_en 0
  - pixel_column 0; pixel_row 0
  - video_on 0; frame_start 0
  - horiz_sync and vert_sync at ~SYNC_ACTIVE
  - delay pipeline filled with the inactive pattern
- Divider:
  - counts 0..CLK_DIV-1 and wraps.
  - pix_en is 1 in the clk cycle after the count equals CLK_DIV-1. First pix_en is CLK_DIV clocks after reset deasserts.
  - CLK_DIV=1: pix_en is held at 1 after the first post-reset clock.
- Horizontal counter: advances only when pix_en=1. At H_TOTAL-1 it wraps to 0.
- Vertical counter: advances only on the pix_en where the horizontal counter wraps. At V_TOTAL-1 it wraps to 0 together with the horizontal wrap.
- pixel_column/pixel_row are the counters directly, with no delay.
- Undelayed decodes are computed from the counter values presented at each pix_en:
  - act = col<H_ACTIVE && row<V_ACTIVE
  - hs = col in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] → 656..751
  - vs = row in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] → 490..491
- Delay pipeline:
  - PIPE_DLY-stage shift register of {act,hs,vs}, shifted only on pix_en.
  - Outputs change only in the cycle after a pix_en.
  - PIPE_DLY=0 registers the decodes directly, with no extra delay.
- Sync polarity: output = SYNC_ACTIVE when decode true, else ~SYNC_ACTIVE.
- frame_start: high for exactly one clk, the cycle after the pix_en on which the counters move from (799,524) to (0,0). It does not fire on the first tick after reset.
- Reset mid-frame:
  - next clk edge returns everything to reset values, regardless of pix_en phase.
  - no partial sync pulse survives; the pipeline is cleared.
- Reset held: outputs stay static, and pix_en never pulses.
- Arithmetic: unsigned 10-bit counters. Width rules: H_TOTAL ≤ 1024 and V_TOTAL ≤ 1024, checked in simulation by an elaboration-time assertion.

Decomposition:
- Shared package vga_pkg:
  - 640x480 timing constants (H_ACTIVE...V_BP)
  - derived H_TOTAL/V_TOTAL
  - 10-bit coordinate width constant
  - SYNC_ACTIVE default
- One natural sub-module: pix_clk_en (parameterised CLK_DIV divider producing pix_en). It is reused by the colorizer testbench.
- Counters, decode and delay line stay in vga_timing_gen.

Test Plan:
- Reset, then 10 clks with reset=1: every output at its reset value. After release, the first pix_en appears at clk 4 and then every 4th clk.
- Free run one line: 640 video_on-high ticks per active line. horiz_sync low (SYNC_ACTIVE=0) for 96 ticks = 384 clks, starting 2 ticks after pixel_column=656. Line period is 3200 clks.
- Free run two frames:
  - frame_start pulses are 1,680,000 clks apart (800×525×4).
  - vert_sync low for 2 lines (6400 clks), starting 2 ticks after row 490, col 0.
  - pixel_row peaks at 524.
- Boundary wrap: at (799,524) the next pix_en gives (0,0) plus a frame_start pulse. At (799,479) the next tick gives row 480, and video_on falls 2 ticks later.
- Reset asserted mid-hsync (col 700, row 100) for 1 clk: the next cycle shows col 0, row 0, syncs high, video_on 0. Normal timing resumes and the first pix_en comes 4 clks later.
- Parameter sweep CLK_DIV=1, PIPE_DLY=0: pix_en constantly high after the first clk. hsync is exactly aligned to pixel_column 656..751 with one clk of register latency.
